// File: rtl/alu_vec_if.sv
// Operand/result bundle for the alu_vec execute-stage ALU.
// Defining ALU_FLAGS_EN adds the zero/carry result flags.
interface alu_vec_if;
  logic [2:0]  op;
  logic        form;
  logic [1:0]  vec;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] C;
  logic [31:0] D;
  logic [3:0]  copy_select;
  logic [31:0] Y1;
  logic [31:0] Y2;
`ifdef ALU_FLAGS_EN
  logic        zero;
  logic        carry;
`endif

  modport master (
    output op, form, vec, A, B, C, D, copy_select,
`ifdef ALU_FLAGS_EN
    input  zero, carry,
`endif
    input  Y1, Y2
  );

  modport slave (
    input  op, form, vec, A, B, C, D, copy_select,
`ifdef ALU_FLAGS_EN
    output zero, carry,
`endif
    output Y1, Y2
  );
endinterface

// File: rtl/alu_vec.sv
// Registered 32-bit SIMD/wide ALU producing a 64-bit result as {Y1, Y2}, one-cycle latency.
// Optional zero/carry flags are built when ALU_FLAGS_EN is defined.
module alu_vec (
  input  logic       clk,
  input  logic       rst,
  alu_vec_if.slave   bus
);

  typedef enum logic [2:0] {
    OpAdd   = 3'b000,
    OpAnd   = 3'b001,
    OpCpInv = 3'b010,
    OpXor   = 3'b011,
    OpSub   = 3'b100,
    OpOr    = 3'b101,
    OpCpClr = 3'b110,
    OpNor   = 3'b111
  } op_e;

  // Byte-sliced add/sub; the carry chain is cut (re-seeded) at every lane start.
  function automatic logic [31:0] lane_arith(input logic [31:0] x, input logic [31:0] y,
                                             input logic sub, input logic [1:0] vec);
    logic [31:0] yy;
    logic [31:0] r;
    logic [8:0]  s;
    logic        c;
    yy = sub ? ~y : y;
    r  = '0;
    c  = sub;
    for (int i = 0; i < 4; i++) begin
      if ((vec == 2'd0) || ((vec == 2'd1) && (i == 2))) c = sub;
      s = {1'b0, x[8*i +: 8]} + {1'b0, yy[8*i +: 8]} + {8'b0, c};
      r[8*i +: 8] = s[7:0];
      c = s[8];
    end
    return r;
  endfunction

  logic [31:0] y1_d, y2_d, y1_q, y2_q;
  logic [63:0] wide;
  logic [31:0] mask, lx1, ly1, lx2, ly2, src1, src2;
  logic        is_sub;

  always_comb begin
    y1_d   = '0;
    y2_d   = '0;
    wide   = '0;
    is_sub = bus.op[2];
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{bus.copy_select[i]}};
    lx1  = bus.A;
    ly1  = bus.form ? bus.B : bus.C;
    lx2  = bus.form ? bus.C : bus.B;
    ly2  = bus.D;
    src1 = bus.form ? bus.C : bus.A;
    src2 = bus.form ? bus.D : bus.B;

    unique case (op_e'(bus.op))
      OpAdd, OpSub: begin
        if (bus.form) begin
          wide = is_sub ? ({32'd0, bus.A} - {32'd0, bus.B} - {32'd0, bus.C})
                        : ({32'd0, bus.A} + {32'd0, bus.B} + {32'd0, bus.C});
          {y1_d, y2_d} = wide;
        end else if (bus.vec == 2'd3) begin
          wide = is_sub ? ({bus.A, bus.B} - {bus.C, bus.D}) : ({bus.A, bus.B} + {bus.C, bus.D});
          {y1_d, y2_d} = wide;
        end else begin
          y1_d = lane_arith(bus.A, bus.C, is_sub, bus.vec);
          y2_d = lane_arith(bus.B, bus.D, is_sub, bus.vec);
        end
      end
      OpAnd: begin
        y1_d = lx1 & ly1;
        y2_d = lx2 & ly2;
      end
      OpOr: begin
        y1_d = lx1 | ly1;
        y2_d = lx2 | ly2;
      end
      OpXor: begin
        y1_d = lx1 ^ ly1;
        y2_d = lx2 ^ ly2;
      end
      OpNor: begin
        y1_d = ~(lx1 | ly1);
        y2_d = ~(lx2 | ly2);
      end
      OpCpInv: begin
        y1_d = src1 ^ mask;
        y2_d = src2 ^ mask;
      end
      OpCpClr: begin
        y1_d = src1 & ~mask;
        y2_d = src2 & ~mask;
      end
      default: begin
        y1_d = '0;
        y2_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y1_q <= '0;
      y2_q <= '0;
    end else begin
      y1_q <= y1_d;
      y2_q <= y2_d;
    end
  end

  assign bus.Y1 = y1_q;
  assign bus.Y2 = y2_q;

`ifdef ALU_FLAGS_EN
  logic        zero_d, carry_d, zero_q, carry_q;
  logic [64:0] s65;
  logic [5:0]  top_w, top_sh;
  logic [31:0] a_top, c_top;
  logic [32:0] t33;

  // Carry/borrow out of the most-significant lane of Y1 (or of bit 63 for wide forms).
  always_comb begin
    carry_d = 1'b0;
    s65     = {1'b0, bus.A, bus.B} + {1'b0, bus.C, bus.D};
    top_w   = 6'd8 << bus.vec;
    top_sh  = 6'd32 - top_w;
    a_top   = bus.A >> top_sh;
    c_top   = bus.C >> top_sh;
    t33     = {1'b0, a_top} + {1'b0, c_top};
    if (bus.op[1:0] == 2'b00) begin
      if (bus.form) begin
        // A+B+C of zero-extended words never reaches bit 64; only the borrow can fire.
        carry_d = bus.op[2] & (({1'b0, bus.B} + {1'b0, bus.C}) > {1'b0, bus.A});
      end else if (bus.vec == 2'd3) begin
        carry_d = bus.op[2] ? ({bus.A, bus.B} < {bus.C, bus.D}) : s65[64];
      end else begin
        carry_d = bus.op[2] ? (a_top < c_top) : t33[top_w];
      end
    end
    zero_d = ~|{y1_d, y2_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign bus.zero  = zero_q;
  assign bus.carry = carry_q;
`endif

endmodule

// File: tb/tb_alu_vec.sv
// Self-checking bench for alu_vec: directed vector table plus random vectors, scoreboard-checked.
module tb_alu_vec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_vec_if bus ();

  alu_vec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [31:0] a, b, c, d;
    logic [3:0]  cs;
    logic [31:0] y1, y2;
    logic        zero, carry;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] y1, y2;
    logic        zero, carry;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic r, logic [2:0] op, logic form, logic [1:0] vec,
                              logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d,
                              logic [3:0] cs, logic [31:0] y1, logic [31:0] y2,
                              logic zero, logic carry);
    vec_t v;
    v.rst = r; v.op = op; v.form = form; v.vec = vec;
    v.a = a; v.b = b; v.c = c; v.d = d; v.cs = cs;
    v.y1 = y1; v.y2 = y2; v.zero = zero; v.carry = carry;
    return v;
  endfunction

  // Lane-at-a-time reference using plain wide arithmetic and masks.
  function automatic logic [31:0] ref_lanes(logic [31:0] x, logic [31:0] y, logic sub,
                                            int w, output logic cy);
    logic [63:0] msk, lx, ly, s, res;
    res = 64'd0;
    cy  = 1'b0;
    msk = (64'd1 << w) - 64'd1;
    for (int off = 0; off < 32; off += w) begin
      lx  = ({32'd0, x} >> off) & msk;
      ly  = ({32'd0, y} >> off) & msk;
      s   = sub ? (lx - ly) : (lx + ly);
      res = res | ((s & msk) << off);
      cy  = s[w];
    end
    return res[31:0];
  endfunction

  function automatic exp_t model(logic [2:0] op, logic form, logic [1:0] vec, logic [31:0] a,
                                 logic [31:0] b, logic [31:0] c, logic [31:0] d, logic [3:0] cs);
    exp_t        e;
    logic [65:0] s66;
    logic [64:0] s65;
    logic [31:0] m, p1, q1, p2, q2;
    logic        cy, dummy;
    e.id = 0; e.y1 = '0; e.y2 = '0; cy = 1'b0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = cs[i] ? 8'hFF : 8'h00;
    p1 = a; q1 = form ? b : c; p2 = form ? c : b; q2 = d;
    case (op)
      3'b000, 3'b100: begin
        if (form) begin
          s66 = op[2] ? (66'(a) - 66'(b) - 66'(c)) : (66'(a) + 66'(b) + 66'(c));
          {e.y1, e.y2} = s66[63:0];
          cy = s66[64];
        end else if (vec == 2'd3) begin
          s65 = op[2] ? ({1'b0, a, b} - {1'b0, c, d}) : ({1'b0, a, b} + {1'b0, c, d});
          {e.y1, e.y2} = s65[63:0];
          cy = s65[64];
        end else begin
          e.y1 = ref_lanes(a, c, op[2], 8 << vec, cy);
          e.y2 = ref_lanes(b, d, op[2], 8 << vec, dummy);
        end
      end
      3'b001: begin e.y1 = p1 & q1; e.y2 = p2 & q2; end
      3'b101: begin e.y1 = p1 | q1; e.y2 = p2 | q2; end
      3'b011: begin e.y1 = p1 ^ q1; e.y2 = p2 ^ q2; end
      3'b111: begin e.y1 = ~(p1 | q1); e.y2 = ~(p2 | q2); end
      3'b010: begin e.y1 = (form ? c : a) ^ m; e.y2 = (form ? d : b) ^ m; end
      default: begin e.y1 = (form ? c : a) & ~m; e.y2 = (form ? d : b) & ~m; end
    endcase
    e.zero  = ({e.y1, e.y2} == 64'd0);
    e.carry = cy;
    return e;
  endfunction

  task automatic chk(string nm, int id, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h, required %h", nm, id, act, req);
    end
  endtask

  task automatic drive(vec_t v, int id, logic use_model);
    exp_t e;
    @(negedge clk);
    rst             = v.rst;
    bus.op          = v.op;
    bus.form        = v.form;
    bus.vec         = v.vec;
    bus.A           = v.a;
    bus.B           = v.b;
    bus.C           = v.c;
    bus.D           = v.d;
    bus.copy_select = v.cs;
    if (use_model) begin
      e = model(v.op, v.form, v.vec, v.a, v.b, v.c, v.d, v.cs);
    end else begin
      e.y1 = v.y1; e.y2 = v.y2; e.zero = v.zero; e.carry = v.carry;
    end
    e.id = id;
    sb.push_back(e);
  endtask

  // Each result must appear on the edge that samples its inputs.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("y1", e.id, bus.Y1, e.y1);
      chk("y2", e.id, bus.Y2, e.y2);
`ifdef ALU_FLAGS_EN
      chk("zero", e.id, {31'd0, bus.zero}, {31'd0, e.zero});
      chk("carry", e.id, {31'd0, bus.carry}, {31'd0, e.carry});
`endif
    end
  end

  vec_t tbl[24];

  initial begin
    vec_t rv;
    bus.op = '0; bus.form = 1'b0; bus.vec = '0; bus.copy_select = '0;
    bus.A = '0; bus.B = '0; bus.C = '0; bus.D = '0;

    //              rst op      f     vec   A             B             C             D             cs     Y1            Y2            z     c
    tbl[0]  = mk(1, 3'b000, 1'b1, 2'd2, 32'h1234_5678, 32'h9, 32'h7, 32'h5, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[1]  = mk(0, 3'b000, 1'b1, 2'd2, 32'd1, 32'd2, 32'd3, 32'd2, 4'h0, 32'd0, 32'd6, 1'b0, 1'b0);
    tbl[2]  = mk(0, 3'b000, 1'b0, 2'd2, 32'd1, 32'd2, 32'd3, 32'd2, 4'h0, 32'd4, 32'd4, 1'b0, 1'b0);
    tbl[3]  = mk(0, 3'b000, 1'b0, 2'd3, 32'd1, 32'd2, 32'd3, 32'd2, 4'h0, 32'd4, 32'd4, 1'b0, 1'b0);
    tbl[4]  = mk(0, 3'b000, 1'b0, 2'd1, 32'd1, 32'd2, 32'd3, 32'd2, 4'h0, 32'd4, 32'd4, 1'b0, 1'b0);
    tbl[5]  = mk(0, 3'b000, 1'b0, 2'd1, 32'h0001_FFFF, 32'd2, 32'd1, 32'd2, 4'h0,
                 32'h0001_0000, 32'd4, 1'b0, 1'b0);
    tbl[6]  = mk(0, 3'b100, 1'b1, 2'd2, 32'd1, 32'd2, 32'd3, 32'd2, 4'h0,
                 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0, 1'b1);
    tbl[7]  = mk(0, 3'b100, 1'b0, 2'd2, 32'd1, 32'd2, 32'd3, 32'd2, 4'h0,
                 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b1);
    tbl[8]  = mk(0, 3'b010, 1'b1, 2'd2, 32'd1, 32'd2, 32'd3, 32'd2, 4'h1, 32'd252, 32'hFD, 1'b0, 1'b0);
    tbl[9]  = mk(0, 3'b110, 1'b1, 2'd2, 32'd1, 32'd2, 32'd3, 32'd2, 4'hF, 32'd0, 32'd0, 1'b1, 1'b0);
    tbl[10] = mk(0, 3'b101, 1'b0, 2'd0, 32'hF0, 32'd1, 32'h0F, 32'd2, 4'h0, 32'hFF, 32'd3, 1'b0, 1'b0);
    tbl[11] = mk(0, 3'b001, 1'b0, 2'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h00FF_00FF,
                 4'h0, 32'hF000_F000, 32'h000F_000F, 1'b0, 1'b0);
    tbl[12] = mk(0, 3'b011, 1'b1, 2'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h00FF_00FF,
                 4'h0, 32'hF00F_F00F, 32'hF00F_F00F, 1'b0, 1'b0);
    tbl[13] = mk(0, 3'b111, 1'b0, 2'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h00FF_00FF,
                 4'h0, 32'h000F_000F, 32'hF000_F000, 1'b0, 1'b0);
    tbl[14] = mk(0, 3'b000, 1'b0, 2'd0, 32'h80FF_7F01, 32'h0102_0304, 32'h8001_0102, 32'hFFFF_FFFF,
                 4'h0, 32'h0000_8003, 32'h0001_0203, 1'b0, 1'b1);
    tbl[15] = mk(0, 3'b100, 1'b0, 2'd0, 32'h0001_0203, 32'h1020_3040, 32'h0101_0101, 32'h0102_0304,
                 4'h0, 32'hFF00_0102, 32'h0F1E_2D3C, 1'b0, 1'b1);
    tbl[16] = mk(0, 3'b000, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 4'h0,
                 32'd0, 32'd0, 1'b1, 1'b1);
    tbl[17] = mk(0, 3'b100, 1'b0, 2'd1, 32'h0000_0001, 32'h0005_0000, 32'h0000_0002, 32'h0001_0001,
                 4'h0, 32'h0000_FFFF, 32'h0004_FFFF, 1'b0, 1'b0);
    tbl[18] = mk(0, 3'b110, 1'b0, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 4'h5,
                 32'h1200_5600, 32'h9A00_DE00, 1'b0, 1'b0);
    tbl[19] = mk(0, 3'b010, 1'b0, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 4'hA,
                 32'hED34_A978, 32'h65BC_21F0, 1'b0, 1'b0);
    tbl[20] = mk(0, 3'b000, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 4'h0,
                 32'd0, 32'd0, 1'b1, 1'b1);
    tbl[21] = mk(0, 3'b000, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 4'h0,
                 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
    tbl[22] = mk(0, 3'b100, 1'b1, 2'd1, 32'd5, 32'd2, 32'd3, 32'd7, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    tbl[23] = mk(1, 3'b011, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 4'hF,
                 32'd0, 32'd0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < 24; i++) drive(tbl[i], i, 1'b0);

    // Back-to-back random traffic, biased toward all-ones operands to exercise carries.
    for (int i = 0; i < 80; i++) begin
      rv.rst  = 1'b0;
      rv.op   = 3'($urandom_range(0, 7));
      rv.form = 1'($urandom_range(0, 1));
      rv.vec  = 2'($urandom_range(0, 3));
      rv.a    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rv.b    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rv.c    = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
      rv.d    = $urandom;
      rv.cs   = 4'($urandom_range(0, 15));
      rv.y1 = '0; rv.y2 = '0; rv.zero = 1'b0; rv.carry = 1'b0;
      drive(rv, 100 + i, 1'b1);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("drain", 999, 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
